// File: rtl/npu_layer_sched_if.sv
// ---------------------------------------------------------------------------
// npu_layer_sched_if
// Handshake bundle between the layer scheduler and the NPU datapath.
//   master (scheduler): drives the layer-parameter fetch request and the
//                       per-layer start/index/address outputs.
//   slave  (datapath):  returns fetch accept, parameter-delivered and
//                       layer-finished pulses.
// Signals:
//   lp_req / lp_addr / lp_ack / lp_done      layer-parameter fetch handshake
//   layer_start / layer_idx                  layer launch and its index
//   layer_src_saddr / layer_dst_saddr        feature-map addresses for the layer
//   layer_done                               datapath finished the layer
// ---------------------------------------------------------------------------
interface npu_layer_sched_if #(
    parameter int DDR_AW = 32
);
    logic              lp_req;
    logic [DDR_AW-1:0] lp_addr;
    logic              lp_ack;
    logic              lp_done;
    logic              layer_start;
    logic [7:0]        layer_idx;
    logic [DDR_AW-1:0] layer_src_saddr;
    logic [DDR_AW-1:0] layer_dst_saddr;
    logic              layer_done;

    modport master (
        output lp_req, lp_addr, layer_start, layer_idx,
               layer_src_saddr, layer_dst_saddr,
        input  lp_ack, lp_done, layer_done
    );

    modport slave (
        input  lp_req, lp_addr, layer_start, layer_idx,
               layer_src_saddr, layer_dst_saddr,
        output lp_ack, lp_done, layer_done
    );
endinterface

// File: rtl/npu_layer_sched.sv
// ---------------------------------------------------------------------------
// npu_layer_sched
// Layer-level sequencer: once enabled and configured, fetches each layer's
// parameter record, launches the layer with ping-pong feature-map addresses
// and reports busy / first-map-expired / done status.
// Ports:
//   clk_trans, rst_n             clock, async active-low reset
//   npu_en_processing            run enable level (falling mid-run aborts)
//   npu_init_cmplt               configuration-complete level
//   nn_layers_num                number of layers (0 = never starts)
//   nn_layer_para_saddr          base of the layer-parameter records
//   nn_first_map_saddr           input image address
//   nn_map0_saddr/nn_map1_saddr  ping/pong feature-map buffers
//   dp (master modport)          fetch and layer handshake to the datapath
//   npu_busy                     run in progress
//   first_map_expired_flg        1-cycle pulse when layer 0 completes
//   npu_done                     1-cycle pulse when the last layer completes
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for enable + init-complete with a nonzero layer count
// FETCH_REQ  | lp_req held with stable lp_addr until lp_ack
// FETCH_WAIT | waiting for the parameter record to be delivered (lp_done)
// EXEC_START | layer_start pulse, layer outputs become valid
// EXEC_WAIT  | waiting for layer_done, then next layer / DONE / IDLE
// DONE       | run complete; held until enable drops so a held enable
//            | cannot re-trigger a run
// ---------------------------------------------------------------------------
module npu_layer_sched #(
    parameter int DDR_AW   = 32,
    parameter int LP_BYTES = 64
) (
    input  logic              clk_trans,
    input  logic              rst_n,
    input  logic              npu_en_processing,
    input  logic              npu_init_cmplt,
    input  logic [7:0]        nn_layers_num,
    input  logic [DDR_AW-1:0] nn_layer_para_saddr,
    input  logic [DDR_AW-1:0] nn_first_map_saddr,
    input  logic [DDR_AW-1:0] nn_map0_saddr,
    input  logic [DDR_AW-1:0] nn_map1_saddr,
    npu_layer_sched_if.master dp,
    output logic              npu_busy,
    output logic              first_map_expired_flg,
    output logic              npu_done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        EXEC_START = 3'd3,
        EXEC_WAIT  = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              abort_q, abort_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        num_q;
    logic [DDR_AW-1:0] first_q, map0_q, map1_q;
    logic              latch_cfg;

    logic              lp_req_d, start_d, busy_d, fme_d, done_d;
    logic [DDR_AW-1:0] lp_addr_d, src_d, dst_d;
    logic [7:0]        lidx_d;

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= IDLE;
            abort_q               <= 1'b0;
            idx_q                 <= '0;
            num_q                 <= '0;
            first_q               <= '0;
            map0_q                <= '0;
            map1_q                <= '0;
            dp.lp_req             <= 1'b0;
            dp.lp_addr            <= '0;
            dp.layer_start        <= 1'b0;
            dp.layer_idx          <= '0;
            dp.layer_src_saddr    <= '0;
            dp.layer_dst_saddr    <= '0;
            npu_busy              <= 1'b0;
            first_map_expired_flg <= 1'b0;
            npu_done              <= 1'b0;
        end else begin
            state_q               <= state_d;
            abort_q               <= abort_d;
            idx_q                 <= idx_d;
            if (latch_cfg) begin
                num_q   <= nn_layers_num;
                first_q <= nn_first_map_saddr;
                map0_q  <= nn_map0_saddr;
                map1_q  <= nn_map1_saddr;
            end
            dp.lp_req             <= lp_req_d;
            dp.lp_addr            <= lp_addr_d;
            dp.layer_start        <= start_d;
            dp.layer_idx          <= lidx_d;
            dp.layer_src_saddr    <= src_d;
            dp.layer_dst_saddr    <= dst_d;
            npu_busy              <= busy_d;
            first_map_expired_flg <= fme_d;
            npu_done              <= done_d;
        end
    end

    // Outputs are computed from the next state and registered, so they line
    // up with the state register instead of lagging it by a cycle.
    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        idx_d     = idx_q;
        latch_cfg = 1'b0;
        lp_req_d  = 1'b0;
        lp_addr_d = dp.lp_addr;
        start_d   = 1'b0;
        lidx_d    = dp.layer_idx;
        src_d     = dp.layer_src_saddr;
        dst_d     = dp.layer_dst_saddr;
        fme_d     = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (npu_en_processing && npu_init_cmplt && (nn_layers_num != 8'd0)) begin
                    latch_cfg = 1'b1;
                    idx_d     = '0;
                    // lp_addr doubles as the running record pointer: it
                    // starts at the base and advances one record per layer.
                    lp_addr_d = nn_layer_para_saddr;
                    lp_req_d  = 1'b1;
                    state_d   = FETCH_REQ;
                end
            end

            FETCH_REQ: begin
                if (dp.lp_ack) begin
                    if (!npu_en_processing) abort_d = 1'b1;
                    state_d = FETCH_WAIT;
                end else if (!npu_en_processing) begin
                    // Nothing accepted yet, so the request can simply be withdrawn.
                    state_d = IDLE;
                end else begin
                    lp_req_d = 1'b1;
                end
            end

            FETCH_WAIT: begin
                if (!npu_en_processing) abort_d = 1'b1;
                if (dp.lp_done) begin
                    if (abort_q || !npu_en_processing) begin
                        state_d = IDLE;
                    end else begin
                        start_d = 1'b1;
                        lidx_d  = idx_q;
                        if (idx_q == 8'd0) begin
                            src_d = first_q;
                            dst_d = map0_q;
                        end else if (idx_q[0]) begin
                            src_d = map0_q;
                            dst_d = map1_q;
                        end else begin
                            src_d = map1_q;
                            dst_d = map0_q;
                        end
                        state_d = EXEC_START;
                    end
                end
            end

            EXEC_START: begin
                if (!npu_en_processing) abort_d = 1'b1;
                state_d = EXEC_WAIT;
            end

            EXEC_WAIT: begin
                if (!npu_en_processing) abort_d = 1'b1;
                if (dp.layer_done) begin
                    // The input image buffer is free once layer 0 finishes,
                    // even on an aborted run.
                    if (idx_q == 8'd0) fme_d = 1'b1;
                    if (abort_q || !npu_en_processing) begin
                        state_d = IDLE;
                    end else if (idx_q == num_q - 8'd1) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        lp_addr_d = dp.lp_addr + DDR_AW'(LP_BYTES);
                        lp_req_d  = 1'b1;
                        state_d   = FETCH_REQ;
                    end
                end
            end

            DONE: begin
                if (!npu_en_processing) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) abort_d = 1'b0;

        busy_d = (state_d == FETCH_REQ)  || (state_d == FETCH_WAIT) ||
                 (state_d == EXEC_START) || (state_d == EXEC_WAIT);
    end

endmodule
